// File: rtl/spi_apb_pkg.sv
// Shared constants for the SPI APB register front-end: register map,
// write masks, status bit positions and state encodings.
package spi_apb_pkg;

    localparam logic [2:0] ADDR_CR1 = 3'd0;
    localparam logic [2:0] ADDR_CR2 = 3'd1;
    localparam logic [2:0] ADDR_BR  = 3'd2;
    localparam logic [2:0] ADDR_SR  = 3'd3;
    localparam logic [2:0] ADDR_DR  = 3'd5;
    localparam logic [2:0] ADDR_LVL = 3'd6;

    localparam logic [7:0] CR1_RESET = 8'h04;
    localparam logic [7:0] CR2_MASK  = 8'h1B;
    localparam logic [7:0] BR_MASK   = 8'h77;

    // CR1 bit positions
    localparam int CR1_SPIE  = 7;
    localparam int CR1_SPE   = 6;
    localparam int CR1_SPTIE = 5;
    localparam int CR1_MSTR  = 4;
    localparam int CR1_CPOL  = 3;
    localparam int CR1_CPHA  = 2;
    localparam int CR1_SSOE  = 1;
    localparam int CR1_LSBFE = 0;

    // CR2 bit positions (stored and write-only strobes)
    localparam int CR2_TXFLUSH = 7;
    localparam int CR2_RXFLUSH = 6;
    localparam int CR2_MODFEN  = 4;
    localparam int CR2_SPISWAI = 1;

    // SR bit positions
    localparam int SR_SPIF  = 7;
    localparam int SR_RXOVR = 6;
    localparam int SR_SPTEF = 5;
    localparam int SR_MODF  = 4;
    localparam int SR_TXE   = 3;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'b00,
        APB_SETUP  = 2'b01,
        APB_ENABLE = 2'b10
    } apb_state_t;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_WAIT = 2'b01,
        MODE_STOP = 2'b10
    } spi_mode_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO used for both the TX and RX frame queues.
// A pop on a full FIFO frees the slot for a push in the same cycle;
// flush empties the FIFO and overrides any push or pop.
module spi_sync_fifo #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          P_clk,
    input  logic                          P_rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DW-1:0]                 wdata,
    output logic [DW-1:0]                 rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array; no reset needed since occupancy gates visibility.
    always_ff @(posedge P_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spi_apb_fifo_if.sv
// APB slave front-end for an SPI core: control/baud registers, status,
// TX/RX frame FIFOs and the RUN/WAIT/STOP low-power mode sequencer.
//
// APB FSM   state  | meaning
//           IDLE   | no transfer
//           SETUP  | address phase, P_enable low
//           ENABLE | access phase, P_ready high, access commits on exit edge
// Mode FSM  RUN    | core active
//           WAIT   | spe cleared, core idle
//           STOP   | spiswai set while idle; TX gated, RX frames ignored
module spi_apb_fifo_if #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          P_clk,
    input  logic          P_rst,
    input  logic          P_sel,
    input  logic          P_enable,
    input  logic          P_write,
    input  logic [2:0]    P_addr,
    input  logic [DW-1:0] P_wdata,
    output logic [DW-1:0] P_rdata,
    output logic          P_ready,
    output logic          P_slverr,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    input  logic          tip,
    input  logic          ss,
    output logic          mstr,
    output logic          cpol,
    output logic          cpha,
    output logic          lsbfe,
    output logic          spiswai,
    output logic [2:0]    spr,
    output logic [2:0]    sppr,
    output logic [1:0]    spi_mode,
    output logic          spi_interrupt_request
);

    import spi_apb_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    apb_state_t    apb_state, apb_next;
    spi_mode_t     mode_q, mode_next;
    logic [7:0]    cr1, cr2, br, sr;
    logic          rxovr;
    logic          access, err, ok;
    logic          wr_cr1, wr_cr2, wr_br, sr_rd;
    logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic          overrun, modf;
    logic [DW-1:0] rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic [9:0]    lvl;

    assign access   = (apb_state == APB_ENABLE);
    assign P_ready  = access;
    assign P_slverr = err;
    assign ok       = access & ~err;

    assign wr_cr1   = ok & P_write & (P_addr == ADDR_CR1);
    assign wr_cr2   = ok & P_write & (P_addr == ADDR_CR2);
    assign wr_br    = ok & P_write & (P_addr == ADDR_BR);
    assign sr_rd    = ok & ~P_write & (P_addr == ADDR_SR);
    assign tx_push  = ok & P_write & (P_addr == ADDR_DR);
    assign rx_pop   = ok & ~P_write & (P_addr == ADDR_DR);
    assign tx_flush = wr_cr2 & P_wdata[CR2_TXFLUSH];
    assign rx_flush = wr_cr2 & P_wdata[CR2_RXFLUSH];

    assign tx_valid = ~tx_empty & (mode_q != MODE_STOP);
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & (mode_q != MODE_STOP);
    assign overrun  = rx_push & rx_full & ~rx_pop & ~rx_flush;

    assign modf = cr1[CR1_MSTR] & cr2[CR2_MODFEN] & ~cr1[CR1_SSOE] & ~ss;
    // Counts are zero-extended to 5 bits each; the packed pair is truncated to DW on read.
    assign lvl  = {5'(rx_count), 5'(tx_count)};

    assign mstr     = cr1[CR1_MSTR];
    assign cpol     = cr1[CR1_CPOL];
    assign cpha     = cr1[CR1_CPHA];
    assign lsbfe    = cr1[CR1_LSBFE];
    assign spiswai  = cr2[CR2_SPISWAI];
    assign spr      = br[2:0];
    assign sppr     = br[6:4];
    assign spi_mode = mode_q;

    spi_sync_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .P_clk (P_clk),
        .P_rst (P_rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .wdata (P_wdata),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    spi_sync_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .P_clk (P_clk),
        .P_rst (P_rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // APB and mode state registers.
    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            apb_state <= APB_IDLE;
            mode_q    <= MODE_RUN;
        end else begin
            apb_state <= apb_next;
            mode_q    <= mode_next;
        end
    end

    // APB handshake sequencing.
    always_comb begin
        apb_next = apb_state;
        case (apb_state)
            APB_IDLE:   apb_next = (P_sel && !P_enable) ? APB_SETUP : APB_IDLE;
            APB_SETUP: begin
                if (P_sel && P_enable)       apb_next = APB_ENABLE;
                else if (P_sel && !P_enable) apb_next = APB_SETUP;
                else                         apb_next = APB_IDLE;
            end
            APB_ENABLE: apb_next = P_sel ? APB_SETUP : APB_IDLE;
            default:    apb_next = APB_IDLE;
        endcase
    end

    // Low-power mode sequencing driven by spe and spiswai.
    always_comb begin
        mode_next = mode_q;
        case (mode_q)
            MODE_RUN:  if (!cr1[CR1_SPE]) mode_next = MODE_WAIT;
            MODE_WAIT: begin
                if (cr1[CR1_SPE])          mode_next = MODE_RUN;
                else if (cr2[CR2_SPISWAI]) mode_next = MODE_STOP;
            end
            MODE_STOP: begin
                if (cr1[CR1_SPE])           mode_next = MODE_RUN;
                else if (!cr2[CR2_SPISWAI]) mode_next = MODE_WAIT;
            end
            default:   mode_next = MODE_RUN;
        endcase
    end

    // Control registers and the sticky overrun flag; a new overrun beats an SR-read clear.
    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            cr1   <= CR1_RESET;
            cr2   <= 8'h00;
            br    <= 8'h00;
            rxovr <= 1'b0;
        end else begin
            if (wr_cr1) cr1 <= P_wdata[7:0];
            if (wr_cr2) cr2 <= P_wdata[7:0] & CR2_MASK;
            if (wr_br)  br  <= P_wdata[7:0] & BR_MASK;
            if (overrun)    rxovr <= 1'b1;
            else if (sr_rd) rxovr <= 1'b0;
        end
    end

    // Access error decode: full/empty DR, writes to read-only, unmapped addresses.
    always_comb begin
        err = 1'b0;
        if (access) begin
            case (P_addr)
                ADDR_CR1, ADDR_CR2, ADDR_BR: err = 1'b0;
                ADDR_DR:                     err = P_write ? tx_full : rx_empty;
                ADDR_SR, ADDR_LVL:           err = P_write;
                default:                     err = 1'b1;
            endcase
        end
    end

    // Live status view.
    always_comb begin
        sr           = 8'h00;
        sr[SR_SPIF]  = ~rx_empty;
        sr[SR_RXOVR] = rxovr;
        sr[SR_SPTEF] = ~tx_full;
        sr[SR_MODF]  = modf;
        sr[SR_TXE]   = tx_empty & ~tip;
    end

    // Read mux, driven only during a successful read access.
    always_comb begin
        P_rdata = '0;
        if (ok && !P_write) begin
            case (P_addr)
                ADDR_CR1: P_rdata[7:0] = cr1;
                ADDR_CR2: P_rdata[7:0] = cr2;
                ADDR_BR:  P_rdata[7:0] = br;
                ADDR_SR:  P_rdata[7:0] = sr;
                ADDR_DR:  P_rdata      = rx_head;
                ADDR_LVL: P_rdata      = DW'(lvl);
                default:  P_rdata      = '0;
            endcase
        end
    end

    // Interrupt request from enabled status sources.
    always_comb begin
        spi_interrupt_request = (cr1[CR1_SPIE] & (sr[SR_SPIF] | sr[SR_MODF] | sr[SR_RXOVR]))
                              | (cr1[CR1_SPTIE] & sr[SR_SPTEF]);
    end

endmodule

// File: tb/tb_spi_apb_fifo_if.sv
// Directed bench for spi_apb_fifo_if: APB accesses queue their expected
// read data / error into a scoreboard; a monitor checks every P_ready cycle.
module tb_spi_apb_fifo_if;

    localparam int DW = 8;
    localparam int FIFO_DEPTH = 4;

    logic          P_clk = 1'b0;
    logic          P_rst = 1'b0;
    logic          P_sel = 1'b0;
    logic          P_enable = 1'b0;
    logic          P_write = 1'b0;
    logic [2:0]    P_addr = 3'd0;
    logic [DW-1:0] P_wdata = '0;
    logic [DW-1:0] P_rdata;
    logic          P_ready;
    logic          P_slverr;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          tip = 1'b1;
    logic          ss = 1'b1;
    logic          mstr, cpol, cpha, lsbfe, spiswai;
    logic [2:0]    spr, sppr;
    logic [1:0]    spi_mode;
    logic          spi_interrupt_request;

    typedef struct {
        string      name;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [2:0] A_CR1 = 3'd0, A_CR2 = 3'd1, A_BR = 3'd2, A_SR = 3'd3;
    localparam logic [2:0] A_DR  = 3'd5, A_LVL = 3'd6;

    spi_apb_fifo_if #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .P_clk                 (P_clk),
        .P_rst                 (P_rst),
        .P_sel                 (P_sel),
        .P_enable              (P_enable),
        .P_write               (P_write),
        .P_addr                (P_addr),
        .P_wdata               (P_wdata),
        .P_rdata               (P_rdata),
        .P_ready               (P_ready),
        .P_slverr              (P_slverr),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .rx_data               (rx_data),
        .rx_valid              (rx_valid),
        .tip                   (tip),
        .ss                    (ss),
        .mstr                  (mstr),
        .cpol                  (cpol),
        .cpha                  (cpha),
        .lsbfe                 (lsbfe),
        .spiswai               (spiswai),
        .spr                   (spr),
        .sppr                  (sppr),
        .spi_mode              (spi_mode),
        .spi_interrupt_request (spi_interrupt_request)
    );

    always #5 P_clk = ~P_clk;

    // Scoreboard monitor: every ready cycle must match the oldest queued expectation.
    always @(negedge P_clk) begin : monitor
        exp_t e;
        if (P_rst && P_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ready: P_ready=1 rdata=%h slverr=%b, required no access", P_rdata, P_slverr);
            end else begin
                e = exp_q.pop_front();
                if (P_rdata !== e.rdata || P_slverr !== e.err) begin
                    n_bad++;
                    $display("FAIL %s: rdata=%h slverr=%b, required rdata=%h slverr=%b",
                             e.name, P_rdata, P_slverr, e.rdata, e.err);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // One APB transfer; optional RX push / TX pop coincide with the commit edge.
    task automatic apb(input logic wr, input logic [2:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input logic exp_err, input string nm,
                       input logic rxp, input logic [7:0] rxd, input logic txp);
        @(posedge P_clk); #1;
        P_sel = 1'b1; P_enable = 1'b0; P_write = wr; P_addr = addr; P_wdata = wd;
        @(posedge P_clk); #1;
        P_enable = 1'b1;
        exp_q.push_back('{nm, exp_rd, exp_err});
        @(posedge P_clk); #1;
        if (rxp) begin rx_valid = 1'b1; rx_data = rxd; end
        if (txp) tx_ready = 1'b1;
        @(posedge P_clk); #1;
        rx_valid = 1'b0; tx_ready = 1'b0; P_sel = 1'b0; P_enable = 1'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] d, input logic e, input string nm);
        apb(1'b1, addr, d, 8'h00, e, nm, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [2:0] addr, input logic [7:0] x, input logic e, input string nm);
        apb(1'b0, addr, 8'h00, x, e, nm, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic push_rx(input logic [7:0] d);
        @(posedge P_clk); #1;
        rx_valid = 1'b1; rx_data = d;
        @(posedge P_clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_ready", 16'(P_ready), 16'h0);
        chk("rst_tx_valid", 16'(tx_valid), 16'h0);
        chk("rst_mode", 16'(spi_mode), 16'h0);
        repeat (3) @(posedge P_clk);
        #1 P_rst = 1'b1;
        repeat (3) @(negedge P_clk);
        chk("mode_run_to_wait", 16'(spi_mode), 16'h1);

        rd(A_CR1, 8'h04, 1'b0, "rst_cr1");
        rd(A_CR2, 8'h00, 1'b0, "rst_cr2");
        rd(A_BR,  8'h00, 1'b0, "rst_br");
        rd(A_SR,  8'h20, 1'b0, "rst_sr_tip");
        rd(A_LVL, 8'h00, 1'b0, "rst_lvl");
        tip = 1'b0;
        rd(A_SR,  8'h28, 1'b0, "sr_txe");

        // Masks and error map
        wr(A_BR, 8'hFF, 1'b0, "br_wr");
        rd(A_BR, 8'h77, 1'b0, "br_mask");
        @(negedge P_clk);
        chk("spr", 16'(spr), 16'h7);
        chk("sppr", 16'(sppr), 16'h7);
        wr(A_CR2, 8'h21, 1'b0, "cr2_wr");
        rd(A_CR2, 8'h01, 1'b0, "cr2_mask");
        wr(A_CR2, 8'h00, 1'b0, "cr2_clr");
        wr(A_SR, 8'hFF, 1'b1, "sr_wr_err");
        wr(A_LVL, 8'hFF, 1'b1, "lvl_wr_err");
        rd(3'd4, 8'h00, 1'b1, "addr4_rd_err");
        wr(3'd7, 8'h55, 1'b1, "addr7_wr_err");
        wr(3'd4, 8'hFF, 1'b1, "addr4_wr_err");
        rd(A_SR, 8'h28, 1'b0, "sr_after_err");

        // TX fill to full
        wr(A_DR, 8'hA1, 1'b0, "tx_wr1");
        wr(A_DR, 8'hA2, 1'b0, "tx_wr2");
        wr(A_DR, 8'hA3, 1'b0, "tx_wr3");
        wr(A_DR, 8'hA4, 1'b0, "tx_wr4");
        wr(A_DR, 8'hA5, 1'b1, "tx_wr_full_err");
        rd(A_LVL, 8'h04, 1'b0, "lvl_tx4");
        rd(A_SR, 8'h00, 1'b0, "sr_tx_full");
        @(negedge P_clk);
        chk("tx_valid_wait", 16'(tx_valid), 16'h1);
        chk("tx_head_a1", 16'(tx_data), 16'h00A1);

        // RX overrun and draining
        for (int i = 0; i < 5; i++) push_rx(8'h11 + 8'(i));
        rd(A_LVL, 8'h84, 1'b0, "lvl_rx4");
        rd(A_SR, 8'hC0, 1'b0, "sr_rxovr");
        rd(A_SR, 8'h80, 1'b0, "sr_rxovr_clr");
        apb(1'b0, A_DR, 8'h00, 8'h11, 1'b0, "rx_pop_push_full", 1'b1, 8'h16, 1'b0);
        rd(A_LVL, 8'h84, 1'b0, "lvl_rx_still4");
        rd(A_SR, 8'h80, 1'b0, "sr_no_ovr");
        rd(A_DR, 8'h12, 1'b0, "rx_rd_12");
        rd(A_DR, 8'h13, 1'b0, "rx_rd_13");
        rd(A_DR, 8'h14, 1'b0, "rx_rd_14");
        rd(A_DR, 8'h16, 1'b0, "rx_rd_16");
        rd(A_DR, 8'h00, 1'b1, "rx_rd_empty_err");
        rd(A_SR, 8'h00, 1'b0, "sr_rx_empty");

        // Mode sequencing
        wr(A_CR1, 8'h10, 1'b0, "cr1_mstr");
        wr(A_CR2, 8'h02, 1'b0, "cr2_spiswai");
        repeat (2) @(negedge P_clk);
        chk("mstr", 16'(mstr), 16'h1);
        chk("spiswai", 16'(spiswai), 16'h1);
        chk("mode_stop", 16'(spi_mode), 16'h2);
        chk("tx_valid_stop", 16'(tx_valid), 16'h0);
        push_rx(8'h77);
        rd(A_LVL, 8'h04, 1'b0, "lvl_rx_ignored_stop");
        rd(A_SR, 8'h00, 1'b0, "sr_no_ovr_stop");
        wr(A_CR1, 8'h40, 1'b0, "cr1_spe");
        repeat (2) @(negedge P_clk);
        chk("mode_run", 16'(spi_mode), 16'h0);
        chk("tx_valid_run", 16'(tx_valid), 16'h1);

        // TX pops, push+pop, rejected write on full with pop
        @(posedge P_clk); #1 tx_ready = 1'b1;
        @(posedge P_clk); #1 tx_ready = 1'b0;
        @(negedge P_clk);
        chk("tx_head_a2", 16'(tx_data), 16'h00A2);
        rd(A_LVL, 8'h03, 1'b0, "lvl_tx3");
        apb(1'b1, A_DR, 8'hA6, 8'h00, 1'b0, "tx_push_pop", 1'b0, 8'h00, 1'b1);
        rd(A_LVL, 8'h03, 1'b0, "lvl_push_pop");
        @(negedge P_clk);
        chk("tx_head_a3", 16'(tx_data), 16'h00A3);
        wr(A_DR, 8'hA7, 1'b0, "tx_wr_a7");
        apb(1'b1, A_DR, 8'hA8, 8'h00, 1'b1, "tx_full_pop_err", 1'b0, 8'h00, 1'b1);
        rd(A_LVL, 8'h03, 1'b0, "lvl_after_reject");
        @(negedge P_clk);
        chk("tx_head_a4", 16'(tx_data), 16'h00A4);

        // Mode fault, interrupt, TX flush
        wr(A_CR1, 8'hB0, 1'b0, "cr1_b0");
        wr(A_CR2, 8'h10, 1'b0, "cr2_modfen");
        ss = 1'b0;
        @(negedge P_clk);
        chk("irq_modf", 16'(spi_interrupt_request), 16'h1);
        rd(A_SR, 8'h30, 1'b0, "sr_modf");
        wr(A_CR2, 8'h80, 1'b0, "cr2_txflush");
        rd(A_LVL, 8'h00, 1'b0, "lvl_flushed");
        rd(A_CR2, 8'h00, 1'b0, "cr2_flush_not_stored");
        rd(A_SR, 8'h28, 1'b0, "sr_after_flush");
        @(negedge P_clk);
        chk("tx_valid_flushed", 16'(tx_valid), 16'h0);
        wr(A_CR1, 8'h80, 1'b0, "cr1_spie_only");
        @(negedge P_clk);
        chk("irq_idle", 16'(spi_interrupt_request), 16'h0);

        // Asynchronous reset during an access
        wr(A_DR, 8'h55, 1'b0, "tx_wr_55");
        @(posedge P_clk); #1;
        P_sel = 1'b1; P_enable = 1'b0; P_write = 1'b0; P_addr = A_CR1;
        @(posedge P_clk); #1;
        P_enable = 1'b1;
        @(posedge P_clk); #1;
        chk("ready_before_rst", 16'(P_ready), 16'h1);
        chk("tx_valid_before_rst", 16'(tx_valid), 16'h1);
        #1 P_rst = 1'b0;
        #1;
        chk("ready_async_rst", 16'(P_ready), 16'h0);
        chk("tx_valid_async_rst", 16'(tx_valid), 16'h0);
        P_sel = 1'b0; P_enable = 1'b0;
        @(posedge P_clk); #1 P_rst = 1'b1;
        ss = 1'b1;
        rd(A_LVL, 8'h00, 1'b0, "lvl_after_rst");
        rd(A_CR1, 8'h04, 1'b0, "cr1_after_rst");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge P_clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d accesses never answered, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_apb_fifo_if.md
SPI_APB_FIFO_IF -- requirements
Module: spi_apb_fifo_if

Interface
REQ-001 Parameter DW, default 8, meaning data width of SPI frames and the APB data bus; legal values are 8 and 16.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning entries per TX and RX FIFO; legal values are powers of two from 2 to 16.
REQ-003 P_clk  in  1  APB/system clock; reset P_rst, asynchronous, active-low; clock P_clk.
REQ-004 P_rst  in  1  asynchronous active-low reset.
REQ-005 P_sel, P_enable, P_write  in  1 each  APB control.
REQ-006 P_addr  in  3  register address; P_wdata  in  DW  write data.
REQ-007 P_rdata  out  DW  read data; P_ready  out  1; P_slverr  out  1.
REQ-008 tx_data  out  DW  TX FIFO head; tx_valid  out  1; tx_ready  in  1  core pops TX on tx_valid&tx_ready.
REQ-009 rx_data  in  DW; rx_valid  in  1  one-cycle push of a received frame.
REQ-010 tip  in  1  transfer in progress; ss  in  1  slave select, active-low.
REQ-011 mstr, cpol, cpha, lsbfe, spiswai  out  1 each; spr, sppr  out  3 each; spi_mode  out  2; spi_interrupt_request  out  1.

Function
REQ-012 APB FSM IDLE->SETUP on P_sel&!P_enable; SETUP->ENABLE on P_sel&P_enable; SETUP stays on P_sel&!P_enable, else IDLE; ENABLE->SETUP if P_sel, else IDLE.
REQ-013 Zero-wait accesses: P_ready=1 only in ENABLE; writes and pops take effect at the clock edge that leaves ENABLE.
REQ-014 Map: 0 CR1 (rw), 1 CR2 (rw, mask 0x1B), 2 BR (rw, mask 0x77), 3 SR (ro), 5 DR (write=TX push, read=RX pop), 6 LVL (ro: {rx_count,tx_count}, each 5 bits zero-extended); control registers use P_wdata[7:0], upper bits read 0.
REQ-015 CR1 bits: 7 spie, 6 spe, 5 sptie, 4 mstr, 3 cpol, 2 cpha, 1 ssoe, 0 lsbfe; CR2 bits: 4 modfen, 1 spiswai; BR: sppr=[6:4], spr=[2:0].
REQ-016 CR2 write bit7=1 flushes TX FIFO and bit6=1 flushes RX FIFO the same edge; these bits are not stored and read 0.
REQ-017 P_slverr=1 in ENABLE for: DR write with TX full, DR read with RX empty, write to SR/LVL, any access to addresses 4 or 7; an erroring access changes no state.
REQ-018 P_rdata is 0 outside ENABLE-read; DR read returns RX head combinationally and pops it.
REQ-019 SR: 7 SPIF (RX not empty), 6 RXOVR (sticky), 5 SPTEF (TX not full), 4 MODF = mstr&modfen&!ssoe&!ss, 3 TXE (TX empty & !tip), 2:0 zero; SR updates combinationally from current state.
REQ-020 RXOVR sets when rx_valid arrives with RX full and no same-cycle pop; the frame is dropped; cleared by an SR read, with set winning over clear in the same cycle.
REQ-021 Same-cycle RX push and pop on a full FIFO: both succeed, count unchanged, no overrun.
REQ-022 A TX DR write while TX is full is rejected even if tx_ready pops the same cycle; a push and pop on a non-full FIFO leaves the count unchanged.
REQ-023 Mode FSM RUN(00)/WAIT(01)/STOP(10): RUN->WAIT when !spe; WAIT->RUN if spe, else STOP if spiswai; STOP->RUN if spe, else WAIT if !spiswai.
REQ-024 tx_valid = TX not empty & spi_mode!=STOP; in STOP, rx_valid is ignored and does not set RXOVR.
REQ-025 spi_interrupt_request = (spie&(SPIF|MODF|RXOVR)) | (sptie&SPTEF), combinational.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; counts range 0..FIFO_DEPTH.

Reset
REQ-027 On P_rst low: APB FSM IDLE, spi_mode RUN, CR1=0x04, CR2=0x00, BR=0x00, both FIFOs empty, RXOVR=0.
REQ-028 Reset mid-transfer discards all FIFO contents; tx_valid=0 and P_ready=0 immediately, asynchronously.

Structure
REQ-029 Package spi_apb_pkg holds register address constants, CR2/BR masks, SR bit indices, and APB/mode state encodings.
REQ-030 One sub-module spi_sync_fifo (DW, FIFO_DEPTH; push, pop, flush, full, empty, count) is instantiated twice, for TX and RX.

Verification
REQ-031 Reset, then read CR1/CR2/BR/SR -> 0x04/0x00/0x00/0x20, slverr=0.
REQ-032 Write DR 0xA1,0xA2,0xA3,0xA4,0xA5 (depth 4), tx_ready=0 -> 5th write slverr=1; LVL tx_count=4; SR bit5=0.
REQ-033 Push 5 rx frames 0x11..0x15 with no pops -> RXOVR=1; DR reads return 0x11..0x14; SR read clears RXOVR.
REQ-034 With RX full, rx_valid and a DR read in the same cycle -> no RXOVR, count stays 4.
REQ-035 CR1=0x10 then CR1=0x00 with CR2=0x02 -> spi_mode RUN->WAIT->STOP; tx_valid=0 in STOP; CR1=0x40 -> RUN.
REQ-036 CR1=0xB0 with CR2 modfen=1 and ss=0 -> MODF=1, spi_interrupt_request=1; write CR2=0x80 -> tx_count=0.
